// File: rtl/sd_spi_host.sv
`default_nettype none
// ============================================================================
//  Module   : sd_spi_host
//  Purpose  : Byte-wide SPI master (mode 0, MSB first) for the SD card,
//             mapped as a DATA/CTRL register pair on the 68000 expansion
//             bus. Inserts wait states through xrdy while a byte is in flight.
//  Options  : SPI_TURBO_EN - when defined, speed codes 10/11 run SCLK at
//             cck/2; otherwise those codes fall back to medium speed.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_spi_host (
    input  logic       cck,
    input  logic       _reset,
    input  logic       cckq,
    input  logic       _as,
    input  logic       _ds,
    input  logic       r_w,
    input  logic [6:0] adr,
    inout  wire  [7:0] data,
    output logic       xrdy,
    input  logic       miso,
    output logic       mosi,
    output logic       sclk,
    output logic [3:0] _cs
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [5:0] r_ctrl;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_rxreg;
    logic [7:0] r_dout;
    logic [3:0] r_div;
    logic [3:0] r_half_cnt;
    logic [3:0] r_half_m1;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_handled;
    logic       r_unused_cckq;

    logic       w_sel;
    logic       w_active;
    logic       w_busy;
    logic       w_exec;
    logic       w_launch;
    logic       w_tick;
    logic       w_last;
    logic       w_drive;
    logic [3:0] w_half_m1;
    logic [7:0] w_tx_byte;

    // Address decode and bus-cycle qualification
    assign w_sel     = (adr[6:1] == 6'b111011);
    assign w_active  = w_sel & ~_as;
    assign w_busy    = (r_state == S_XFER);
    assign w_exec    = w_active & ~_ds & ~w_busy & ~r_handled;
    // DATA write sends the CPU byte; CTRL read sends 0xFF to stream the next byte
    assign w_launch  = w_exec & ((~r_w & ~adr[0]) | (r_w & adr[0]));
    assign w_tx_byte = r_w ? 8'hFF : data;

    // A half-period ends when the divider reaches the latched terminal count
    assign w_tick    = w_busy & (r_div == r_half_m1);
    assign w_last    = w_tick & (r_half_cnt == 4'd15);

    // SCLK half-period minus one, from the speed field of CTRL
    always_comb begin
        case (r_ctrl[5:4])
            2'b00:   w_half_m1 = 4'd15;
            2'b01:   w_half_m1 = 4'd3;
`ifdef SPI_TURBO_EN
            default: w_half_m1 = 4'd0;
`else
            default: w_half_m1 = 4'd3;
`endif
        endcase
    end

    // Transfer state register
    always_ff @(posedge cck or negedge _reset) begin
        if (!_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transfer next-state: a byte runs for exactly 16 half-periods
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_nxt = S_XFER;
            S_XFER:  if (w_last)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One action per bus cycle; re-armed only when the address strobe negates
    always_ff @(posedge cck or negedge _reset) begin
        if (!_reset) begin
            r_handled <= 1'b0;
        end else if (_as) begin
            r_handled <= 1'b0;
        end else if (w_exec) begin
            r_handled <= 1'b1;
        end
    end

    // Register file: CTRL write and read-data capture at action time
    always_ff @(posedge cck or negedge _reset) begin
        if (!_reset) begin
            r_ctrl <= 6'd0;
            r_dout <= 8'hFF;
        end else if (w_exec) begin
            if (adr[0] & ~r_w) r_ctrl <= data[5:0];
            if (r_w)           r_dout <= r_rxreg;
        end
    end

    // SPI shift engine: sample MISO on rising SCLK, advance MOSI on falling SCLK
    always_ff @(posedge cck or negedge _reset) begin
        if (!_reset) begin
            r_tx       <= 8'hFF;
            r_rx       <= 8'h00;
            r_rxreg    <= 8'hFF;
            r_div      <= 4'd0;
            r_half_cnt <= 4'd0;
            r_half_m1  <= 4'd0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b1;
        end else if (w_launch) begin
            // Speed is latched here so it applies to the whole byte
            r_tx       <= w_tx_byte;
            r_mosi     <= w_tx_byte[7];
            r_div      <= 4'd0;
            r_half_cnt <= 4'd0;
            r_half_m1  <= w_half_m1;
        end else if (w_busy) begin
            if (w_tick) begin
                r_div      <= 4'd0;
                r_sclk     <= ~r_sclk;
                r_half_cnt <= r_half_cnt + 4'd1;
                if (!r_sclk) begin
                    r_rx <= {r_rx[6:0], miso};
                end else begin
                    // Ones are shifted in so MOSI idles high after the byte
                    r_tx   <= {r_tx[6:0], 1'b1};
                    r_mosi <= r_tx[6];
                end
                if (w_last) r_rxreg <= r_rx;
            end else begin
                r_div <= r_div + 4'd1;
            end
        end
    end

    // Quadrature clock is only sampled so the pin stays connected
    always_ff @(posedge cck or negedge _reset) begin
        if (!_reset) begin
            r_unused_cckq <= 1'b0;
        end else begin
            r_unused_cckq <= cckq;
        end
    end

    // Wait states only while a not-yet-handled cycle is blocked by a transfer
    assign xrdy    = ~(w_active & ~r_handled & w_busy);
    assign w_drive = w_sel & r_w & ~_ds;
    assign data    = w_drive ? r_dout : 8'hzz;
    assign _cs     = ~r_ctrl[3:0];
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_host.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_spi_host
//  Purpose  : Self-checking bench for sd_spi_host: vector table for the
//             streaming/stall sequences, hand-written multi-cycle corner
//             cases, and a randomized run against a byte-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_spi_host;

`ifdef SPI_TURBO_EN
    localparam int TH = 1;
`else
    localparam int TH = 4;
`endif

    logic       cck;
    logic       rst_n;
    logic       cckq;
    logic       as_n;
    logic       ds_n;
    logic       r_w;
    logic [6:0] adr;
    wire  [7:0] data_bus;
    logic       xrdy;
    logic       miso;
    logic       mosi;
    logic       sclk;
    logic [3:0] cs_n;

    logic [7:0] tb_dout;
    logic       tb_den;

    assign data_bus = tb_den ? tb_dout : 8'hzz;

    for (genvar g = 0; g < 8; g++) begin : g_pd
        pulldown pd (data_bus[g]);
    end

    sd_spi_host dut (
        .cck   (cck),
        ._reset(rst_n),
        .cckq  (cckq),
        ._as   (as_n),
        ._ds   (ds_n),
        .r_w   (r_w),
        .adr   (adr),
        .data  (data_bus),
        .xrdy  (xrdy),
        .miso  (miso),
        .mosi  (mosi),
        .sclk  (sclk),
        ._cs   (cs_n)
    );

    initial cck = 1'b0;
    always #5 cck = ~cck;

    initial cckq = 1'b0;
    always @(negedge cck) cckq <= ~cckq;

    int  total = 0;
    int  bad   = 0;

    // SPI card model / monitor
    int  rise_cnt = 0;
    int  fall_cnt = 0;
    int  cs0_rise_at = 0;
    time t_rise = 0;
    time t_fall = 0;
    int  mi_base = 0;
    int  midx;
    bit  mosi_log [0:2047];
    bit  mstream  [0:2047];

    always @(posedge sclk) begin
        mosi_log[rise_cnt % 2048] <= mosi;
        rise_cnt <= rise_cnt + 1;
        t_rise   <= $time;
    end

    always @(negedge sclk) begin
        fall_cnt <= fall_cnt + 1;
        t_fall   <= $time;
    end

    always @(posedge cs_n[0]) cs0_rise_at <= fall_cnt;

    always_comb begin
        midx = (fall_cnt - mi_base) % 2048;
        miso = mstream[midx];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    // One 68000 byte access; holds the strobes until the action edge has passed
    task automatic bus(input bit rd, input bit ctl, input logic [7:0] wd,
                       output logic [7:0] rdv, output int stall);
        @(negedge cck);
        adr     = {6'b111011, ctl};
        r_w     = rd;
        tb_dout = wd;
        tb_den  = !rd;
        as_n    = 1'b0;
        ds_n    = 1'b0;
        stall   = 0;
        #1;
        while (xrdy !== 1'b1 && stall < 3000) begin
            @(negedge cck);
            #1;
            stall++;
        end
        chk("xrdy_release", {31'b0, xrdy}, 32'd1);
        @(posedge cck);
        @(negedge cck);
        #1;
        rdv    = rd ? data_bus : 8'h00;
        as_n   = 1'b1;
        ds_n   = 1'b1;
        tb_den = 1'b0;
        r_w    = 1'b1;
        adr    = 7'd0;
    endtask

    function automatic logic [7:0] stream_byte(input int k);
        logic [7:0] b = 8'h00;
        for (int j = 0; j < 8; j++) b = {b[6:0], mstream[(8 * k + j) % 2048]};
        return b;
    endfunction

    function automatic logic [7:0] log_byte(input int base);
        logic [7:0] b = 8'h00;
        for (int j = 0; j < 8; j++) b = {b[6:0], mosi_log[(base + j) % 2048]};
        return b;
    endfunction

    typedef struct {
        bit         rd;
        bit         ctl;
        logic [7:0] wd;
        bit         chk_rd;
        logic [7:0] exp_rd;
        logic [3:0] exp_cs;
        int         smin;
        int         smax;
    } vec_t;

    function automatic vec_t mk(input bit rd, input bit ctl, input logic [7:0] wd,
                                input bit c, input logic [7:0] er, input logic [3:0] ecs,
                                input int lo, input int hi);
        vec_t v;
        v.rd = rd; v.ctl = ctl; v.wd = wd; v.chk_rd = c; v.exp_rd = er;
        v.exp_cs = ecs; v.smin = lo; v.smax = hi;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [14];
        logic [7:0]  rv;
        int          st;
        int          snap;
        int          gbase;
        logic [31:0] pat;
        logic [31:0] w32;
        logic [5:0]  m_ctrl;
        logic [7:0]  m_rx;
        logic [3:0]  ecs;
        logic [7:0]  exp_tx [$];
        int          nx;
        int          rbase;
        int          fb;
        int          tl;
        int          sl;

        tl = 16 * TH - 4;
        sl = 252;
        vt[0]  = mk(0, 1, 8'h21, 0, 8'h00, 4'hE, 0, 0);
        vt[1]  = mk(0, 0, 8'hFF, 0, 8'h00, 4'hE, 0, 0);
        vt[2]  = mk(1, 1, 8'h00, 1, 8'hDE, 4'hE, tl, 16 * TH);
        vt[3]  = mk(1, 1, 8'h00, 1, 8'hAD, 4'hE, tl, 16 * TH);
        vt[4]  = mk(1, 1, 8'h00, 1, 8'hBE, 4'hE, tl, 16 * TH);
        vt[5]  = mk(1, 0, 8'h00, 1, 8'hEF, 4'hE, tl, 16 * TH);
        vt[6]  = mk(0, 1, 8'h20, 0, 8'h00, 4'hF, 0, 0);
        vt[7]  = mk(0, 1, 8'h01, 0, 8'h00, 4'hE, 0, 0);
        vt[8]  = mk(0, 0, 8'hFF, 0, 8'h00, 4'hE, 0, 0);
        vt[9]  = mk(1, 1, 8'h00, 1, 8'hAB, 4'hE, sl, 256);
        vt[10] = mk(1, 1, 8'h00, 1, 8'hBA, 4'hE, sl, 256);
        vt[11] = mk(1, 1, 8'h00, 1, 8'h12, 4'hE, sl, 256);
        vt[12] = mk(1, 0, 8'h00, 1, 8'h34, 4'hE, sl, 256);
        vt[13] = mk(0, 1, 8'h00, 0, 8'h00, 4'hF, 0, 0);

        rst_n = 1'b0; as_n = 1'b1; ds_n = 1'b1; r_w = 1'b1; adr = 7'd0;
        tb_den = 1'b0; tb_dout = 8'h00;
        for (int i = 0; i < 2048; i++) mstream[i] = 1'b1;

        // ---- reset state ----
        repeat (3) @(negedge cck);
        #1;
        chk("rst_cs", {28'b0, cs_n}, 32'hF);
        chk("rst_sclk", {31'b0, sclk}, 32'd0);
        chk("rst_mosi", {31'b0, mosi}, 32'd1);
        chk("rst_xrdy", {31'b0, xrdy}, 32'd1);
        chk("rst_data_z", {24'b0, data_bus}, 32'h00);
        @(negedge cck);
        rst_n = 1'b1;
        // Selected read with data strobe high must leave the bus undriven
        @(negedge cck);
        adr = 7'b1110110; r_w = 1'b1; as_n = 1'b0; ds_n = 1'b1;
        repeat (2) @(negedge cck);
        #1;
        chk("ds_high_data_z", {24'b0, data_bus}, 32'h00);
        as_n = 1'b1; adr = 7'd0;
        bus(1, 0, 8'h00, rv, st);
        chk("rst_rxreg", {24'b0, rv}, 32'hFF);

        // ---- table: turbo streaming read, then slow streaming read ----
        for (int i = 0; i < 14; i++) begin
            if (i == 0 || i == 7) begin
                pat = (i == 0) ? 32'hDEADBEEF : 32'hABBA1234;
                for (int j = 0; j < 32; j++) mstream[j] = pat[31 - j];
                mi_base = fall_cnt;
                gbase   = rise_cnt;
            end
            bus(vt[i].rd, vt[i].ctl, vt[i].wd, rv, st);
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rd", i), {24'b0, rv}, {24'b0, vt[i].exp_rd});
            chk($sformatf("vec%0d_cs", i), {28'b0, cs_n}, {28'b0, vt[i].exp_cs});
            chk_rng($sformatf("vec%0d_stall", i), st, vt[i].smin, vt[i].smax);
            if (vt[i].rd && !vt[i].ctl) begin
                snap = rise_cnt;
                repeat (300) @(negedge cck);
                chk($sformatf("vec%0d_no_sclk", i), rise_cnt, snap);
            end
            if (i == 6 || i == 13) chk($sformatf("vec%0d_sclk_count", i), rise_cnt - gbase, 32);
        end
        for (int i = 0; i < 2048; i++) mstream[i] = 1'b1;

        // ---- slow back-to-back writes ----
        rbase = rise_cnt;
        bus(0, 0, 8'h12, rv, st); chk_rng("sw_stall0", st, 0, 0);
        bus(0, 0, 8'h34, rv, st); chk_rng("sw_stall1", st, sl, 256);
        bus(0, 0, 8'h56, rv, st); chk_rng("sw_stall2", st, sl, 256);
        bus(0, 0, 8'h78, rv, st); chk_rng("sw_stall3", st, sl, 256);
        repeat (300) @(negedge cck);
        w32 = {log_byte(rbase), log_byte(rbase + 8), log_byte(rbase + 16), log_byte(rbase + 24)};
        chk("sw_mosi", w32, 32'h12345678);

        // ---- control write while busy (medium speed) ----
        bus(0, 1, 8'h11, rv, st);
        fb    = fall_cnt;
        rbase = rise_cnt;
        bus(0, 0, 8'h55, rv, st);
        bus(0, 1, 8'h00, rv, st);
        chk_rng("cw_stall", st, 60, 64);
        chk("cw_cs0_rise_falls", cs0_rise_at - fb, 8);
        chk("cw_cs", {28'b0, cs_n}, 32'hF);
        chk("cw_half", int'((t_fall - t_rise) / 10), 4);
        chk("cw_mosi", {24'b0, log_byte(rbase)}, 32'h55);

        // ---- speed code 10: turbo only when the option is built in ----
        bus(0, 1, 8'h21, rv, st);
        bus(0, 0, 8'h3C, rv, st);
        repeat (80) @(negedge cck);
        chk("cfg_half", int'((t_fall - t_rise) / 10), TH);
        bus(0, 1, 8'h00, rv, st);

        // ---- reset in the middle of a slow transfer ----
        bus(0, 1, 8'h01, rv, st);
        bus(0, 0, 8'hA5, rv, st);
        repeat (40) @(negedge cck);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sclk", {31'b0, sclk}, 32'd0);
        chk("mid_rst_mosi", {31'b0, mosi}, 32'd1);
        chk("mid_rst_cs", {28'b0, cs_n}, 32'hF);
        @(negedge cck);
        rst_n = 1'b1;
        snap = rise_cnt;
        bus(1, 0, 8'h00, rv, st);
        chk("mid_rst_rxreg", {24'b0, rv}, 32'hFF);
        repeat (300) @(negedge cck);
        chk("mid_rst_no_sclk", rise_cnt, snap);

        // ---- aborted cycle: strobe negates before the data strobe arrives ----
        @(negedge cck);
        adr = 7'b1110110; r_w = 1'b0; tb_den = 1'b1; tb_dout = 8'h99;
        as_n = 1'b0; ds_n = 1'b1;
        repeat (3) @(negedge cck);
        as_n = 1'b1; tb_den = 1'b0; r_w = 1'b1; adr = 7'd0;
        snap = rise_cnt;
        repeat (40) @(negedge cck);
        chk("abort_no_xfer", rise_cnt, snap);

        // ---- randomized accesses against a byte-level model ----
        @(negedge cck); rst_n = 1'b0;
        @(negedge cck); rst_n = 1'b1;
        for (int i = 0; i < 2048; i++) mstream[i] = bit'($urandom_range(0, 1));
        mi_base = fall_cnt;
        rbase   = rise_cnt;
        m_rx    = 8'hFF;
        m_ctrl  = 6'd0;
        nx      = 0;
        for (int k = 0; k < 40; k++) begin
            int         op;
            logic [7:0] b;
            op = $urandom_range(0, 3);
            b  = 8'($urandom_range(0, 255));
            case (op)
                0: begin
                    bus(0, 0, b, rv, st);
                    exp_tx.push_back(b);
                    m_rx = stream_byte(nx);
                    nx++;
                end
                1: begin
                    bus(0, 1, b, rv, st);
                    m_ctrl = b[5:0];
                end
                2: begin
                    bus(1, 0, 8'h00, rv, st);
                    chk($sformatf("rnd%0d_rd_data", k), {24'b0, rv}, {24'b0, m_rx});
                end
                default: begin
                    bus(1, 1, 8'h00, rv, st);
                    chk($sformatf("rnd%0d_rd_ctrl", k), {24'b0, rv}, {24'b0, m_rx});
                    exp_tx.push_back(8'hFF);
                    m_rx = stream_byte(nx);
                    nx++;
                end
            endcase
            ecs = ~m_ctrl[3:0];
            chk($sformatf("rnd%0d_cs", k), {28'b0, cs_n}, {28'b0, ecs});
        end
        repeat (300) @(negedge cck);
        chk("rnd_sclk_count", rise_cnt - rbase, 8 * exp_tx.size());
        for (int j = 0; j < exp_tx.size(); j++)
            chk($sformatf("rnd_mosi%0d", j), {24'b0, log_byte(rbase + 8 * j)}, {24'b0, exp_tx[j]});
        chk("end_data_z", {24'b0, data_bus}, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
